// File: rtl/ide_strobe_gen_pkg.sv
// Shared state encoding and counter helpers for the IDE PIO strobe generator.
package ide_strobe_gen_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDE_IDLE     = 3'd0,
    IDE_SETUP    = 3'd1,
    IDE_ACTIVE   = 3'd2,
    IDE_WAIT_RDY = 3'd3,
    IDE_COMPLETE = 3'd4,
    IDE_HOLD     = 3'd5,
    IDE_DONE     = 3'd6
  } ide_state_e;

  // A phase of N clocks counts N-1 down to 0, so the load value is N-1.
  function automatic logic [CNT_W-1:0] clks_to_load(input int unsigned clks);
    clks_to_load = CNT_W'(clks - 32'd1);
  endfunction

endpackage

// File: rtl/ide_strobe_gen_sync2.sv
// Generic 2-flop synchroniser with synchronous active-low reset; resets to 1.
module sync2 (
  input  logic CLK,
  input  logic RESET_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ide_strobe_gen.sv
// IDE PIO strobe generator: times t1 setup, t2 pulse, IORDY wait and t4 hold in CLK cycles.
// Optional IORDY wait timeout is built when IDE_TIMEOUT_EN is defined.
module ide_strobe_gen
  import ide_strobe_gen_pkg::*;
#(
  parameter int unsigned T1_CLKS      = 3,
  parameter int unsigned T2_CLKS      = 7,
  parameter int unsigned T4_CLKS      = 2,
  parameter int unsigned TIMEOUT_CLKS = 255
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic ide_access,
  input  logic AS_n,
  input  logic UDS_n,
  input  logic LDS_n,
  input  logic RW,
  input  logic IORDY,
  output logic IOR_n,
  output logic IOW_n,
  output logic dtack,
  output logic timeout_err
);

  ide_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cyc_rd_q, cyc_rd_d;
  logic             ior_n_q, ior_n_d;
  logic             iow_n_q, iow_n_d;
  logic             dtack_q, dtack_d;
  logic             rdy_s;
  logic             ds_s;
`ifdef IDE_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             terr_q, terr_d;
`else
  logic             unused_tmo_s;
  assign unused_tmo_s = ^CNT_W'(TIMEOUT_CLKS);
`endif

  assign ds_s = !UDS_n || !LDS_n;

  sync2 u_iordy_sync (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .d       (IORDY),
    .q       (rdy_s)
  );

  // Next-state and next-output logic; AS_n high mid-cycle aborts without dtack.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_rd_d = cyc_rd_q;
    ior_n_d  = ior_n_q;
    iow_n_d  = iow_n_q;
    dtack_d  = dtack_q;
`ifdef IDE_TIMEOUT_EN
    tmo_d    = tmo_q;
    terr_d   = terr_q;
`endif
    case (state_q)
      IDE_IDLE: begin
        if (ide_access && !AS_n && ds_s) begin
          cyc_rd_d = RW;
          cnt_d    = clks_to_load(T1_CLKS);
          state_d  = IDE_SETUP;
        end else begin
          state_d  = IDE_IDLE;
        end
      end
      IDE_SETUP: begin
        if (AS_n) begin
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          dtack_d = 1'b0;
          state_d = IDE_IDLE;
        end else if (cnt_q == 8'd0) begin
          if (cyc_rd_q) begin
            ior_n_d = 1'b0;
          end else begin
            iow_n_d = 1'b0;
          end
          cnt_d   = clks_to_load(T2_CLKS);
          state_d = IDE_ACTIVE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      IDE_ACTIVE: begin
        if (AS_n) begin
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          dtack_d = 1'b0;
          state_d = IDE_IDLE;
        end else if (cnt_q == 8'd0) begin
          if (rdy_s) begin
            state_d = IDE_COMPLETE;
          end else begin
            state_d = IDE_WAIT_RDY;
`ifdef IDE_TIMEOUT_EN
            tmo_d   = clks_to_load(TIMEOUT_CLKS);
`endif
          end
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      IDE_WAIT_RDY: begin
        if (AS_n) begin
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          dtack_d = 1'b0;
          state_d = IDE_IDLE;
        end else if (rdy_s) begin
          state_d = IDE_COMPLETE;
`ifdef IDE_TIMEOUT_EN
        end else if (tmo_q == 8'd0) begin
          terr_d  = 1'b1;
          state_d = IDE_COMPLETE;
        end else begin
          tmo_d   = tmo_q - 8'd1;
        end
`else
        end else begin
          state_d = IDE_WAIT_RDY;
        end
`endif
      end
      IDE_COMPLETE: begin
        if (cyc_rd_q) begin
          dtack_d = 1'b1;
          state_d = IDE_DONE;
        end else begin
          iow_n_d = 1'b1;
          cnt_d   = clks_to_load(T4_CLKS);
          state_d = IDE_HOLD;
        end
      end
      IDE_HOLD: begin
        if (AS_n) begin
          ior_n_d = 1'b1;
          iow_n_d = 1'b1;
          dtack_d = 1'b0;
          state_d = IDE_IDLE;
        end else if (cnt_q == 8'd0) begin
          dtack_d = 1'b1;
          state_d = IDE_DONE;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      IDE_DONE: begin
        // Read strobe is held until the CPU ends the cycle so data stays driven.
        if (AS_n) begin
          ior_n_d = 1'b1;
          dtack_d = 1'b0;
          state_d = IDE_IDLE;
        end else begin
          state_d = IDE_DONE;
        end
      end
      default: begin
        ior_n_d = 1'b1;
        iow_n_d = 1'b1;
        dtack_d = 1'b0;
        state_d = IDE_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q  <= IDE_IDLE;
      cnt_q    <= 8'd0;
      cyc_rd_q <= 1'b0;
      ior_n_q  <= 1'b1;
      iow_n_q  <= 1'b1;
      dtack_q  <= 1'b0;
`ifdef IDE_TIMEOUT_EN
      tmo_q    <= 8'd0;
      terr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cyc_rd_q <= cyc_rd_d;
      ior_n_q  <= ior_n_d;
      iow_n_q  <= iow_n_d;
      dtack_q  <= dtack_d;
`ifdef IDE_TIMEOUT_EN
      tmo_q    <= tmo_d;
      terr_q   <= terr_d;
`endif
    end
  end

  assign IOR_n = ior_n_q;
  assign IOW_n = iow_n_q;
  assign dtack = dtack_q;
`ifdef IDE_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ide_strobe_gen.sv
// Bench for ide_strobe_gen: directed and random cycles against an edge-index timing model.
module tb_ide_strobe_gen;

  localparam int T1 = 3;
  localparam int T2 = 7;
  localparam int T4 = 2;
`ifdef IDE_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst_n, ide_access, as_n, uds_n, lds_n, rw, iordy;
  logic ior_n, iow_n, dtack, timeout_err;

  int checks = 0;
  int errors = 0;
  bit exp_terr = 1'b0;

  always #5 clk = ~clk;

  ide_strobe_gen #(
    .T1_CLKS(T1), .T2_CLKS(T2), .T4_CLKS(T4), .TIMEOUT_CLKS(TO)
  ) dut (
    .CLK(clk), .RESET_n(rst_n), .ide_access(ide_access), .AS_n(as_n),
    .UDS_n(uds_n), .LDS_n(lds_n), .RW(rw), .IORDY(iordy),
    .IOR_n(ior_n), .IOW_n(iow_n), .dtack(dtack), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ior, input logic e_iow,
                         input logic e_dt, input logic e_terr);
    chk({tag, ".IOR_n"}, ior_n, e_ior);
    chk({tag, ".IOW_n"}, iow_n, e_iow);
    chk({tag, ".dtack"}, dtack, e_dt);
    chk({tag, ".timeout_err"}, timeout_err, e_terr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_edges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
      ide_access = 1'($urandom); rw = 1'($urandom); iordy = 1'b1;
      tick();
      chk_all(tag, 1'b1, 1'b1, 1'b0, exp_terr);
    end
  endtask

  // IORDY level present at relative edge j: low inside [lo_s, lo_s+lo_len).
  function automatic logic iordy_at(input int j, input int lo_s, input int lo_len);
    return !(j >= lo_s && j < lo_s + lo_len);
  endfunction

  // One bus cycle. Edge 0 is where IDLE sees the start; AS_n is high from edge h on.
  // The FSM sees IORDY of edge k-2 at edge k; c is the edge that enters COMPLETE.
  task automatic run_txn(input logic rd, input int lo_s, input int lo_len,
                         input bit abort, input int h_fix, input string tag);
    int a, c, d, h, rel, iow_end, kmax, sel;
    bit tmo_hit;
    logic e_ior, e_iow, e_dt, e_terr;
    a = T1 + T2;
    tmo_hit = 1'b0;
    c = a;
    while (1) begin
      if (iordy_at(c - 2, lo_s, lo_len)) break;
`ifdef IDE_TIMEOUT_EN
      if (c == a + TO) begin tmo_hit = 1'b1; break; end
`endif
      c++;
      if (c > a + 2000) break;
    end
    d = rd ? c + 1 : c + 1 + T4;
    if (h_fix > 0) h = h_fix;
    else if (abort) h = int'($urandom_range(d, 1));
    else h = d + int'($urandom_range(3, 1));
    rel = (rd && h == c + 1) ? c + 2 : h;
    iow_end = (h < c + 1) ? h : c + 1;
    kmax = ((h > c + 2) ? h : c + 2) + 1;

    sel = int'($urandom_range(2, 0));
    ide_access = 1'b1; as_n = 1'b0; rw = rd;
    uds_n = (sel == 1); lds_n = (sel == 0);
    iordy = iordy_at(0, lo_s, lo_len);
    tick();
    chk_all({tag, "@start"}, 1'b1, 1'b1, 1'b0, exp_terr);
    for (int k = 1; k <= kmax; k++) begin
      as_n = (k >= h);
      rw = 1'($urandom);
      ide_access = 1'($urandom);
      iordy = iordy_at(k, lo_s, lo_len);
      tick();
      e_ior = !(rd && k >= T1 && k < rel);
      e_iow = !(!rd && k >= T1 && k < iow_end);
      if (rd) e_dt = (h >= c + 1) && (k >= c + 1) && (k < rel);
      else    e_dt = (h > d) && (k >= d) && (k < h);
      e_terr = exp_terr || (tmo_hit && h > c && k >= c);
      chk_all($sformatf("%s@k%0d", tag, k), e_ior, e_iow, e_dt, e_terr);
    end
    if (tmo_hit && h > c) exp_terr = 1'b1;
    idle_edges(3, {tag, "@idle"});
  endtask

  initial begin
    rst_n = 1'b0; ide_access = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    rw = 1'b1; iordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    idle_edges(3, "post_reset");

    run_txn(1'b1, 0, 0, 1'b0, 0, "rd_basic");
    run_txn(1'b0, 0, 0, 1'b0, 0, "wr_basic");
    run_txn(1'b1, T1 + T2 - 6, 20, 1'b0, 0, "rd_iordy");
    run_txn(1'b0, 0, 0, 1'b1, T1 + 3, "wr_abort");
    run_txn(1'b0, 0, 0, 1'b0, 0, "wr_after_abort");
    run_txn(1'b1, 0, 0, 1'b1, T1 + T2 + 2, "rd_at_complete");

    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), int'($urandom_range(15, 0)), int'($urandom_range(25, 0)),
              ($urandom_range(3, 0) == 0), 0, $sformatf("rnd%0d", n));
    end

`ifdef IDE_TIMEOUT_EN
    run_txn(1'b1, 0, 60, 1'b0, 0, "timeout");
    idle_edges(4, "terr_sticky");
`endif

    // Reset while waiting on IORDY, then a decoded cycle without data strobes.
    ide_access = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1; rw = 1'b1; iordy = 1'b0;
    for (int i = 0; i < T1 + T2 + 5; i++) tick();
    chk_all("in_wait", 1'b0, 1'b1, 1'b0, exp_terr);
    rst_n = 1'b0;
    tick();
    exp_terr = 1'b0;
    chk_all("reset_in_wait", 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1; as_n = 1'b1; uds_n = 1'b1; iordy = 1'b1;
    idle_edges(3, "after_mid_reset");
    ide_access = 1'b1; as_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_all("no_ds", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle_edges(2, "end_idle");
    run_txn(1'b0, 2, 14, 1'b0, 0, "wr_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
